sync_fifo_bram: RTL and testbench

Single-clock simple-dual-port BRAM responder sitting behind sync_fifo_controller: it serves the controller's port-A writes and port-B reads. It also implements the reset/clear handshake the controller waits on through bram_rst_busy. Used as the synthesizable and simulation-model memory for the FIFO when no vendor BRAM primitive is instantiated. The controller's bram_clka/bram_clkb are tied to the same clk at the top level.

---
 rtl/sync_fifo_bram.sv | 126 ++++++++++++
 tb/tb_sync_fifo_bram.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_bram.sv
// Single-clock simple-dual-port BRAM behind sync_fifo_controller, with clear sweep and busy handshake.
// Define SYNC_FIFO_BRAM_OUTREG_EN to add a second output register (read latency 2).
module sync_fifo_bram #(
  parameter int SIZE       = 31,
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] bram_addra,
  input  logic [DATA_WIDTH-1:0] bram_dina,
  input  logic                  bram_wea,
  input  logic                  bram_ena,
  input  logic                  bram_rsta,
  input  logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic                  bram_enb,
  input  logic                  bram_rstb,
  output logic [DATA_WIDTH-1:0] bram_doutb,
  output logic                  bram_rst_busy
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] clr_ptr, clr_ptr_nx;
  logic                  busy_nx;
  logic                  clr_req;
  logic                  clr_wr;
  logic                  wr_en;
  logic                  rd_en;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] dout_p0;
  logic [DATA_WIDTH-1:0] mem [0:SIZE-1];

  assign clr_req     = bram_rsta | bram_rstb;
  // A clear request owns the edge it is sampled on: no sweep write, no user write, no read.
  assign clr_wr      = (state == CLEAR) && !clr_req;
  assign wr_en       = bram_ena && bram_wea && !bram_rst_busy && !clr_req &&
                       (32'(bram_addra) < SIZE);
  assign rd_en       = bram_enb && !bram_rst_busy && !clr_req;
  assign rd_in_range = 32'(bram_addrb) < SIZE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= CLEAR;
      clr_ptr       <= '0;
      bram_rst_busy <= 1'b1;
    end else begin
      state         <= state_nx;
      clr_ptr       <= clr_ptr_nx;
      bram_rst_busy <= busy_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    busy_nx    = bram_rst_busy;
    if (clr_req) begin
      state_nx   = CLEAR;
      clr_ptr_nx = '0;
      busy_nx    = 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_ptr == LAST_ADDR) begin
            state_nx   = IDLE;
            clr_ptr_nx = '0;
            busy_nx    = 1'b0;
          end else begin
            clr_ptr_nx = clr_ptr + 1'b1;
          end
        end
        default: begin
          busy_nx = 1'b0;
        end
      endcase
    end
  end

  // Memory array is never reset; the sweep zeroes it after reset release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_wr)
        mem[clr_ptr] <= '0;
      else if (wr_en)
        mem[bram_addra] <= bram_dina;
    end
  end

  // Read register stage (p0): read-first against a same-cycle write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dout_p0 <= '0;
    else if (bram_rstb)
      dout_p0 <= '0;
    else if (rd_en)
      dout_p0 <= rd_in_range ? mem[bram_addrb] : '0;
  end

`ifdef SYNC_FIFO_BRAM_OUTREG_EN
  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] dout_p1;

  // Output register stage (p1): clock-enabled by the enable delayed one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      dout_p1 <= '0;
    end else begin
      vld_p0 <= bram_enb;
      if (bram_rstb)
        dout_p1 <= '0;
      else if (vld_p0)
        dout_p1 <= dout_p0;
    end
  end

  assign bram_doutb = dout_p1;
`else
  assign bram_doutb = dout_p0;
`endif

endmodule

// File: tb/tb_sync_fifo_bram.sv
// Directed self-checking bench for sync_fifo_bram: sweep timing, read/write, collision, clears, range.
module tb_sync_fifo_bram;

`ifdef SYNC_FIFO_BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  bram_addra;
  logic [23:0] bram_dina;
  logic        bram_wea;
  logic        bram_ena;
  logic        bram_rsta;
  logic [4:0]  bram_addrb;
  logic        bram_enb;
  logic        bram_rstb;
  logic [23:0] bram_doutb;
  logic        bram_rst_busy;

  int total_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [23:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [7];

  sync_fifo_bram dut (
    .clk          (clk),
    .reset        (reset),
    .bram_addra   (bram_addra),
    .bram_dina    (bram_dina),
    .bram_wea     (bram_wea),
    .bram_ena     (bram_ena),
    .bram_rsta    (bram_rsta),
    .bram_addrb   (bram_addrb),
    .bram_enb     (bram_enb),
    .bram_rstb    (bram_rstb),
    .bram_doutb   (bram_doutb),
    .bram_rst_busy(bram_rst_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [23:0] d);
    bram_addra = a; bram_dina = d; bram_ena = 1'b1; bram_wea = 1'b1;
    tick();
    bram_ena = 1'b0; bram_wea = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    bram_addrb = a; bram_enb = 1'b1;
    tick();
    bram_enb = 1'b0;
    if (LAT == 2) tick();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bram_rst_busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    tbl[0] = '{5'd0,  24'd1};
    tbl[1] = '{5'd5,  24'd6};
    tbl[2] = '{5'd30, 24'd31};
    tbl[3] = '{5'd17, 24'd18};
    tbl[4] = '{5'd31, 24'd0};
    tbl[5] = '{5'd1,  24'd2};
    tbl[6] = '{5'd12, 24'd13};

    reset = 1'b1; bram_addra = '0; bram_dina = '0; bram_wea = 1'b0; bram_ena = 1'b0;
    bram_rsta = 1'b0; bram_addrb = '0; bram_enb = 1'b0; bram_rstb = 1'b0;
    repeat (10) tick();
    check("reset_busy", 32'(bram_rst_busy), 32'd1);
    check("reset_doutb", 32'(bram_doutb), 32'd0);
    reset = 1'b0;
    count_busy(n);
    check("reset_sweep_len", n, 32'd31);

    for (int a = 0; a < 31; a++) begin
      rd(5'(a));
      check($sformatf("swept_zero[%0d]", a), 32'(bram_doutb), 32'd0);
    end

    for (int a = 0; a < 31; a++) wr(5'(a), 24'(a + 1));
    for (int i = 0; i < 7; i++) begin
      rd(tbl[i].addr);
      check($sformatf("tbl_read[%0d]", tbl[i].addr), 32'(bram_doutb), 32'(tbl[i].exp));
    end
    bram_addrb = 5'd3;
    repeat (3) tick();
    check("enb_low_hold", 32'(bram_doutb), 32'd13);

    // Same-address write and read in one cycle returns the old word.
    bram_addra = 5'd5; bram_dina = 24'hABCDEF; bram_ena = 1'b1; bram_wea = 1'b1;
    bram_addrb = 5'd5; bram_enb = 1'b1;
    tick();
    bram_ena = 1'b0; bram_wea = 1'b0; bram_enb = 1'b0;
    if (LAT == 2) tick();
    check("collision_old", 32'(bram_doutb), 32'h000006);
    rd(5'd5);
    check("collision_new", 32'(bram_doutb), 32'hABCDEF);

    wr(5'd31, 24'hFFFFFF);
    rd(5'd31);
    check("oor_read", 32'(bram_doutb), 32'd0);
    for (int a = 0; a < 31; a++) begin
      rd(5'(a));
      check($sformatf("oor_intact[%0d]", a), 32'(bram_doutb), (a == 5) ? 32'hABCDEF : 32'(a + 1));
    end

    rd(5'd16);
    check("rstb_pre", 32'(bram_doutb), 32'h000011);
    bram_rstb = 1'b1;
    tick();
    check("rstb_first_edge_doutb", 32'(bram_doutb), 32'd0);
    check("rstb_busy", 32'(bram_rst_busy), 32'd1);
    repeat (3) tick();
    bram_rstb = 1'b0;
    count_busy(n);
    check("rstb_sweep_len", n, 32'd31);

    // rsta pulse with a write pending; write and reads are held off through the sweep.
    wr(5'd7, 24'h000042);
    rd(5'd7);
    check("rsta_pre", 32'(bram_doutb), 32'h000042);
    bram_rsta = 1'b1;
    bram_addra = 5'd3; bram_dina = 24'h123456; bram_ena = 1'b1; bram_wea = 1'b1;
    bram_addrb = 5'd9; bram_enb = 1'b1;
    tick();
    bram_rsta = 1'b0;
    check("rsta_busy", 32'(bram_rst_busy), 32'd1);
    check("rsta_doutb_kept", 32'(bram_doutb), 32'h000042);
    count_busy(n);
    bram_ena = 1'b0; bram_wea = 1'b0; bram_enb = 1'b0;
    check("rsta_sweep_len", n, 32'd31);
    check("busy_read_ignored", 32'(bram_doutb), 32'h000042);
    rd(5'd3);
    check("busy_write_dropped", 32'(bram_doutb), 32'd0);
    rd(5'd7);
    check("rsta_cleared", 32'(bram_doutb), 32'd0);

    // Async reset in the middle of a sweep restarts it.
    wr(5'd9, 24'h00005A);
    rd(5'd9);
    check("areset_pre", 32'(bram_doutb), 32'h00005A);
    bram_rsta = 1'b1;
    tick();
    bram_rsta = 1'b0;
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    check("areset_busy", 32'(bram_rst_busy), 32'd1);
    check("areset_doutb", 32'(bram_doutb), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    count_busy(n);
    check("areset_sweep_len", n, 32'd31);
    rd(5'd30);
    check("areset_swept", 32'(bram_doutb), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
